// File: rtl/async_fifo.sv
// FIFO with Gray-coded pointers crossing two-flop synchronizers on a single clock,
// so flag and count latency match a true dual-clock build and the domains can be split later.

module async_fifo_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q2
);
  logic [W-1:0] q1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= '0;
      q2 <= '0;
    end else begin
      q1 <= d;
      q2 <= q1;
    end
  end
endmodule

module async_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8   // power of two, >= 4
) (
  input  logic                      write_clk,
  input  logic                      write_reset_n,
  input  logic                      write_en,
  input  logic [DATA_WIDTH-1:0]     write_data,
  input  logic                      read_en,
  output logic [DATA_WIDTH-1:0]     read_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int ADDR = $clog2(DEPTH);

  typedef logic [ADDR:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[ADDR] = g[ADDR];
    for (int i = ADDR - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  ptr_t wbin, rbin, wgray, rgray;
  ptr_t wbin_nxt, rbin_nxt;
  ptr_t rq2, wq2;
  logic wr_ok, rd_ok;

  assign wr_ok    = write_en & ~full;
  assign rd_ok    = read_en & ~empty;
  assign wbin_nxt = wbin + ptr_t'(1);
  assign rbin_nxt = rbin + ptr_t'(1);

  // Storage is not reset; only pointers define which words are valid.
  always_ff @(posedge write_clk) begin
    if (wr_ok) mem[wbin[ADDR-1:0]] <= write_data;
  end

  always_ff @(posedge write_clk or negedge write_reset_n) begin
    if (!write_reset_n) begin
      wbin  <= '0;
      wgray <= '0;
    end else if (wr_ok) begin
      wbin  <= wbin_nxt;
      wgray <= bin2gray(wbin_nxt);
    end
  end

  always_ff @(posedge write_clk or negedge write_reset_n) begin
    if (!write_reset_n) begin
      rbin      <= '0;
      rgray     <= '0;
      read_data <= '0;
    end else if (rd_ok) begin
      rbin      <= rbin_nxt;
      rgray     <= bin2gray(rbin_nxt);
      read_data <= mem[rbin[ADDR-1:0]];
    end
  end

  async_fifo_sync #(.W(ADDR+1)) u_r2w (
    .clk  (write_clk),
    .rst_n(write_reset_n),
    .d    (rgray),
    .q2   (rq2)
  );

  async_fifo_sync #(.W(ADDR+1)) u_w2r (
    .clk  (write_clk),
    .rst_n(write_reset_n),
    .d    (wgray),
    .q2   (wq2)
  );

  // Flags compare own pointer against the stale view of the other side, so they only err conservative.
  assign empty = (rgray == wq2);
  assign full  = (wgray == {~rq2[ADDR:ADDR-1], rq2[ADDR-2:0]});
  assign count = wbin - gray2bin(rq2);
endmodule

// File: tb/tb_async_fifo.sv
// Self-checking bench for async_fifo: directed vector table, latency sequences,
// and a randomized run against a queue-based reference model.

module tb_async_fifo;
  localparam int DW = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we = 1'b0;
  logic          re = 1'b0;
  logic [DW-1:0] wd = '0;
  logic [DW-1:0] rd;
  logic          full, empty;
  logic [3:0]    count;

  int tests = 0;
  int fails = 0;

  async_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .write_clk    (clk),
    .write_reset_n(rst_n),
    .write_en     (we),
    .write_data   (wd),
    .read_en      (re),
    .read_data    (rd),
    .full         (full),
    .empty        (empty),
    .count        (count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          we;
    logic [DW-1:0] wd;
    logic          re;
    logic          e;
    logic          f;
    logic [3:0]    c;
    logic [DW-1:0] rd;
  } vec_t;

  vec_t vt[20];
  logic [DW-1:0] q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    we = 1'b0;
    re = 1'b0;
    rst_n = 1'b0;
    repeat (3) begin
      step();
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_rdata", 32'(rd), 0);
    end
    rst_n = 1'b1;
  endtask

  // Flag sanity against the model: flags may lag but never claim capacity or data that is not there.
  task automatic chk_cons();
    chk("cons_empty", 32'(!empty && q.size() == 0), 0);
    chk("cons_full", 32'(!full && q.size() >= DEPTH), 0);
    chk("cons_count", 32'(int'(count) < q.size() || int'(count) > DEPTH), 0);
  endtask

  initial begin
    logic [DW-1:0] d, e;
    int waits;
    int op;

    @(negedge clk);
    do_reset();

    // fill, overfill, drain, extra read, settle
    vt[0]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 4'd1, 8'h00};
    vt[1]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 4'd2, 8'h00};
    vt[2]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 4'd3, 8'h00};
    vt[3]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 4'd4, 8'h00};
    vt[4]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 4'd5, 8'h00};
    vt[5]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 4'd6, 8'h00};
    vt[6]  = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 4'd7, 8'h00};
    vt[7]  = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 4'd8, 8'h00};
    vt[8]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 4'd8, 8'h00};
    vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4'd8, 8'h00};
    vt[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4'd8, 8'h11};
    vt[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd7, 8'h22};
    vt[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd6, 8'h33};
    vt[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd5, 8'h44};
    vt[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd4, 8'h55};
    vt[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd3, 8'h66};
    vt[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd2, 8'h77};
    vt[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd1, 8'h77};
    vt[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 8'h77};
    vt[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 8'h77};

    for (int i = 0; i < 20; i++) begin
      we = vt[i].we;
      wd = vt[i].wd;
      re = vt[i].re;
      step();
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vt[i].e));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(vt[i].f));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].c));
      chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vt[i].rd));
    end
    we = 1'b0;
    re = 1'b0;

    // empty latency after a single write, then full latency after a single read
    do_reset();
    we = 1'b1; wd = 8'hA5;
    step();
    we = 1'b0;
    chk("lat_empty_N", 32'(empty), 1);
    step();
    chk("lat_empty_N1", 32'(empty), 1);
    step();
    chk("lat_empty_N2", 32'(empty), 0);
    for (int i = 1; i < DEPTH; i++) begin
      we = 1'b1; wd = 8'(i);
      step();
    end
    we = 1'b0;
    chk("lat_full_set", 32'(full), 1);
    re = 1'b1;
    step();
    re = 1'b0;
    chk("lat_rdata", 32'(rd), 32'hA5);
    chk("lat_full_N", 32'(full), 1);
    step();
    chk("lat_full_N1", 32'(full), 1);
    step();
    chk("lat_full_N2", 32'(full), 0);
    chk("lat_count_N2", 32'(count), 7);

    // simultaneous write and read with 3 entries stored
    do_reset();
    q.delete();
    for (int i = 1; i <= 3; i++) begin
      we = 1'b1; wd = 8'(i * 16);
      q.push_back(wd);
      step();
    end
    we = 1'b0;
    repeat (3) step();
    chk("sim_count_pre", 32'(count), 3);
    for (int k = 0; k < 4; k++) begin
      we = 1'b1; re = 1'b1; wd = 8'h40 + 8'(k);
      e = q.pop_front();
      q.push_back(wd);
      step();
      chk($sformatf("sim_rdata%0d", k), 32'(rd), 32'(e));
    end
    we = 1'b0; re = 1'b0;
    repeat (3) step();
    chk("sim_count_post", 32'(count), 3);

    // asynchronous reset with 5 entries stored
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      we = 1'b1; wd = 8'h80 + 8'(i);
      step();
    end
    we = 1'b0;
    repeat (3) step();
    re = 1'b1;
    step();
    re = 1'b0;
    chk("mid_rdata_pre", 32'(rd), 32'h81);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_full", 32'(full), 0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_rdata", 32'(rd), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized blocking writes/reads against a queue model
    do_reset();
    q.delete();
    void'($urandom(32'h1BADB002));
    for (int it = 0; it < 200; it++) begin
      op = int'($urandom_range(0, 3));
      if (op[0] && q.size() < DEPTH) begin
        waits = 0;
        while (full && waits < 20) begin
          chk_cons();
          step();
          waits++;
        end
        if (full) chk("rnd_wr_timeout", 32'(full), 0);
        else begin
          d = 8'($urandom);
          we = 1'b1; wd = d;
          step();
          we = 1'b0;
          q.push_back(d);
        end
      end
      if (op[1] && q.size() > 0) begin
        waits = 0;
        while (empty && waits < 20) begin
          chk_cons();
          step();
          waits++;
        end
        if (empty) chk("rnd_rd_timeout", 32'(empty), 0);
        else begin
          re = 1'b1;
          step();
          re = 1'b0;
          e = q.pop_front();
          chk($sformatf("rnd_rdata%0d", it), 32'(rd), 32'(e));
        end
      end
      if (!op[0] && !op[1]) step();
      chk_cons();
    end
    repeat (3) step();
    chk("rnd_count", 32'(count), 32'(q.size()));
    chk("rnd_empty", 32'(empty), 32'(q.size() == 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
